fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decoder. Owns the PC and issues word requests to instruction memory. Buffers returned words in a 2-entry in-order queue and presents them to the decoder with a valid/ready handshake. Branch/jump resolution redirects the PC and squashes every in-flight and buffered instruction.

---
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and imem requester (imem_req_*/imem_resp_*) feeding a DEPTH-entry instruction queue to the decoder (instr_*), squashed by redirect_*
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [31:0] pc;
  logic [CW-1:0] outstanding, count, drop_cnt;
  logic [31:0] q_data [DEPTH];
  logic [31:0] q_pc [DEPTH];
  logic [31:0] f_pc [DEPTH];
  logic [PW-1:0] q_head, q_tail, f_head, f_tail;
  logic accept, resp_keep, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign imem_req_valid = rst_n & ~redirect_valid & (({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(DEPTH));
  assign imem_req_addr = pc;
  assign accept = imem_req_valid & imem_req_ready;
  assign resp_keep = imem_resp_valid & ~redirect_valid & (drop_cnt == '0);
  assign instr_valid = count != '0;
  assign instr = q_data[q_head];
  assign instr_pc = q_pc[q_head];
  assign pop = instr_valid & instr_ready & ~redirect_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      outstanding <= '0;
      count <= '0;
      drop_cnt <= '0;
      q_head <= '0;
      q_tail <= '0;
      f_head <= '0;
      f_tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i] <= '0;
        f_pc[i] <= '0;
      end
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
      if (accept) begin
        f_pc[f_tail] <= pc;
        f_tail <= inc(f_tail);
      end
      // the tag FIFO pops on every response, kept or dropped, so it never needs an explicit flush
      if (imem_resp_valid) f_head <= inc(f_head);
      if (redirect_valid) begin
        pc <= redirect_pc & ~32'd3;
        drop_cnt <= outstanding - CW'(imem_resp_valid);
        count <= '0;
        q_head <= '0;
        q_tail <= '0;
      end else begin
        if (accept) pc <= pc + 32'd4;
        if (imem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (resp_keep) begin
          q_data[q_tail] <= imem_resp_data;
          q_pc[q_tail] <= f_pc[f_head];
          q_tail <= inc(q_tail);
        end
        if (pop) q_head <= inc(q_head);
        count <= count + CW'(resp_keep) - CW'(pop);
      end
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(resp_keep && count == CW'(DEPTH)));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: in-order memory model plus scoreboard of expected {pc, data} checked against every decoder pop
module tb_fetch_unit;
  logic clk = 0;
  logic rst_n = 1;
  logic imem_req_valid, imem_req_ready, imem_resp_valid, redirect_valid, instr_valid, instr_ready;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, instr, instr_pc;
  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} exp_t;
  typedef struct {int lat; int rnd; int rdy_pct; int pop_pct; int redir_pct; int cycles; logic [31:0] start_pc; logic [31:0] exp_pc;} row_t;
  mreq_t mem_q[$];
  exp_t sb_q[$];
  row_t rows[5];
  int errs = 0, checks = 0, cyc = 0, lat = 1, lat_rnd = 0;
  bit found;
  logic [31:0] saved;
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic monitor();
    exp_t e;
    int d;
    if (!rst_n) begin
      mem_q.delete();
      sb_q.delete();
      return;
    end
    if (imem_resp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (redirect_valid) sb_q.delete();
    else if (instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL sb_extra: got pc %h expected no instruction", instr_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_data", instr, e.data);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      d = lat_rnd != 0 ? int'($urandom_range(1, lat)) : lat;
      mem_q.push_back('{imem_req_addr, cyc + d});
      sb_q.push_back('{imem_req_addr, mdata(imem_req_addr)});
    end
  endtask
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1;
      imem_resp_data = mdata(mem_q[0].addr);
    end else begin
      imem_resp_valid = 0;
      imem_resp_data = 0;
    end
  endtask
  task automatic reset_dut();
    rst_n = 0;
    redirect_valid = 0;
    redirect_pc = 0;
    imem_req_ready = 1;
    tick();
    tick();
    rst_n = 1;
  endtask
  task automatic wait_valid(input string name);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      #2;
      if (instr_valid) begin
        found = 1;
        break;
      end
    end
    chk(name, 32'(found), 1);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    rows[0] = '{1, 0, 100, 100, 0, 40, 32'h0000_1000, 32'h0000_1000};
    rows[1] = '{2, 1, 70, 60, 0, 60, 32'h0000_2002, 32'h0000_2000};
    rows[2] = '{3, 1, 50, 30, 5, 80, 32'h8000_0011, 32'h8000_0010};
    rows[3] = '{4, 0, 100, 20, 3, 80, 32'hFFFF_FFF7, 32'hFFFF_FFF4};
    rows[4] = '{1, 1, 90, 90, 8, 100, 32'h0000_0040, 32'h0000_0040};
    imem_req_ready = 1;
    imem_resp_valid = 0;
    imem_resp_data = 0;
    redirect_valid = 0;
    redirect_pc = 0;
    instr_ready = 0;
    #1 rst_n = 0;
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    lat = 1;
    lat_rnd = 0;
    instr_ready = 1;
    reset_dut();
    #2;
    chk("strm_req_valid0", 32'(imem_req_valid), 1);
    chk("strm_req_addr0", imem_req_addr, 32'h0);
    tick();
    #2;
    chk("strm_req_addr1", imem_req_addr, 32'h4);
    chk("strm_valid1", 32'(instr_valid), 0);
    tick();
    #2;
    chk("strm_valid2", 32'(instr_valid), 1);
    chk("strm_pc2", instr_pc, 32'h0);
    chk("strm_data2", instr, mdata(32'h0));
    repeat (20) tick();
    instr_ready = 0;
    reset_dut();
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_req_off", 32'(imem_req_valid), 0);
      chk("bp_valid", 32'(instr_valid), 1);
      chk("bp_hold_pc", instr_pc, 32'h0);
      chk("bp_hold_data", instr, mdata(32'h0));
      if (i < 2) tick();
    end
    instr_ready = 1;
    tick();
    #2;
    chk("bp_next_pc", instr_pc, 32'h4);
    repeat (10) tick();
    lat = 3;
    reset_dut();
    found = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      #2;
      if (mem_q.size() == 2 && mem_q[0].addr == 32'h8 && !imem_resp_valid) begin
        found = 1;
        break;
      end
    end
    chk("rd2_setup", 32'(found), 1);
    redirect_valid = 1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 0;
    wait_valid("rd2_wait");
    chk("rd2_pc", instr_pc, 32'h100);
    chk("rd2_data", instr, mdata(32'h100));
    repeat (6) tick();
    lat = 1;
    reset_dut();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      #2;
      if (instr_valid && imem_resp_valid) begin
        found = 1;
        break;
      end
    end
    chk("rdc_setup", 32'(found), 1);
    chk("rdc_head_pc", instr_pc, 32'h0);
    redirect_valid = 1;
    redirect_pc = 32'h203;
    tick();
    redirect_valid = 0;
    #2;
    chk("rdc_flushed", 32'(instr_valid), 0);
    chk("rdc_addr", imem_req_addr, 32'h200);
    chk("rdc_req_valid", 32'(imem_req_valid), 1);
    wait_valid("rdc_wait");
    chk("rdc_pc", instr_pc, 32'h200);
    repeat (6) tick();
    reset_dut();
    repeat (6) tick();
    imem_req_ready = 0;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      #2;
      if (imem_req_valid) begin
        found = 1;
        break;
      end
    end
    chk("stall_setup", 32'(found), 1);
    saved = imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      tick();
      #2;
      chk("stall_valid", 32'(imem_req_valid), 1);
      chk("stall_addr", imem_req_addr, saved);
    end
    imem_req_ready = 1;
    tick();
    #2;
    chk("stall_resume", imem_req_addr, saved + 32'd4);
    repeat (8) tick();
    reset_dut();
    #2;
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("redir_req_off", 32'(imem_req_valid), 0);
    tick();
    redirect_valid = 0;
    #2;
    chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_valid0", 32'(imem_req_valid), 1);
    tick();
    #2;
    chk("wrap_addr1", imem_req_addr, 32'h0);
    wait_valid("wrap_wait");
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    tick();
    wait_valid("arst_wait");
    rst_n = 0;
    #1;
    chk("arst_instr_valid", 32'(instr_valid), 0);
    chk("arst_req_valid", 32'(imem_req_valid), 0);
    chk("arst_addr", imem_req_addr, 32'h0);
    chk("arst_instr_pc", instr_pc, 32'h0);
    for (int r = 0; r < 5; r++) begin
      lat = rows[r].lat;
      lat_rnd = rows[r].rnd;
      instr_ready = 0;
      reset_dut();
      redirect_valid = 1;
      redirect_pc = rows[r].start_pc;
      tick();
      redirect_valid = 0;
      wait_valid("tbl_first_wait");
      chk("tbl_first_pc", instr_pc, rows[r].exp_pc);
      chk("tbl_first_data", instr, mdata(rows[r].exp_pc));
      for (int c = 0; c < rows[r].cycles; c++) begin
        tick();
        imem_req_ready = int'($urandom_range(0, 99)) < rows[r].rdy_pct;
        instr_ready = int'($urandom_range(0, 99)) < rows[r].pop_pct;
        redirect_valid = int'($urandom_range(0, 99)) < rows[r].redir_pct;
        redirect_pc = $urandom;
      end
      tick();
      redirect_valid = 0;
      imem_req_ready = 0;
      instr_ready = 1;
      found = 0;
      for (int i = 0; i < 60; i++) begin
        tick();
        #2;
        if (sb_q.size() == 0 && mem_q.size() == 0 && !instr_valid) begin
          found = 1;
          break;
        end
      end
      chk("tbl_drained", 32'(found), 1);
      imem_req_ready = 1;
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
